// File: rtl/lcd_glyph_overlay.sv
// Multi-slot glyph bitmap overlay between the LCD timing generator and panel.
// Define GLYPH_BLINK_EN to honour the per-slot blink attribute.
module lcd_glyph_overlay #(
  parameter int NUM_SLOTS  = 8,
  parameter int GLYPH_W    = 32,
  parameter int GLYPH_H    = 64,
  parameter int NUM_GLYPHS = 16,
  parameter int ROM_LAT    = 2,
  parameter int ROM_AW     = 11,
  parameter int XW         = 11,
  parameter int YW         = 10,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int GW = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1
) (
  input  logic              lcd_clk,
  input  logic              rstn,
  input  logic [XW-1:0]     pix_x,
  input  logic [YW-1:0]     pix_y,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [23:0]       bg_rgb,
  input  logic              cfg_we,
  input  logic [SW-1:0]     cfg_slot,
  input  logic              cfg_en,
  input  logic [XW-1:0]     cfg_x,
  input  logic [YW-1:0]     cfg_y,
  input  logic [GW-1:0]     cfg_glyph,
  input  logic [23:0]       cfg_fg,
  input  logic              cfg_blink,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        lcd_r,
  output logic [7:0]        lcd_g,
  output logic [7:0]        lcd_b,
  output logic              lcd_de,
  output logic              lcd_hsync,
  output logic              lcd_vsync
);

  localparam int BPR = GLYPH_W / 8;
  localparam int CW  = $clog2(GLYPH_W);
  localparam int RW  = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

  logic [NUM_SLOTS-1:0] sh_en, ac_en, vis;
  logic [XW-1:0]        sh_x  [NUM_SLOTS];
  logic [XW-1:0]        ac_x  [NUM_SLOTS];
  logic [YW-1:0]        sh_y  [NUM_SLOTS];
  logic [YW-1:0]        ac_y  [NUM_SLOTS];
  logic [GW-1:0]        sh_g  [NUM_SLOTS];
  logic [GW-1:0]        ac_g  [NUM_SLOTS];
  logic [23:0]          sh_fg [NUM_SLOTS];
  logic [23:0]          ac_fg [NUM_SLOTS];

  logic vs_q, v_fall;

  always_ff @(posedge lcd_clk) begin
    if (!rstn) vs_q <= 1'b1;
    else       vs_q <= vsync_in;
  end

  assign v_fall = vs_q & ~vsync_in;

  always_ff @(posedge lcd_clk) begin
    if (!rstn) begin
      sh_en <= '0;
      sh_x  <= '{default: '0};
      sh_y  <= '{default: '0};
      sh_g  <= '{default: '0};
      sh_fg <= '{default: '0};
    end else if (cfg_we && (int'(cfg_slot) < NUM_SLOTS)) begin
      sh_en[cfg_slot] <= cfg_en;
      sh_x[cfg_slot]  <= cfg_x;
      sh_y[cfg_slot]  <= cfg_y;
      sh_g[cfg_slot]  <= cfg_glyph;
      sh_fg[cfg_slot] <= cfg_fg;
    end
  end

  // Active set only changes at frame start so a frame never tears.
  always_ff @(posedge lcd_clk) begin
    if (!rstn) begin
      ac_en <= '0;
      ac_x  <= '{default: '0};
      ac_y  <= '{default: '0};
      ac_g  <= '{default: '0};
      ac_fg <= '{default: '0};
    end else if (v_fall) begin
      ac_en <= sh_en;
      ac_x  <= sh_x;
      ac_y  <= sh_y;
      ac_g  <= sh_g;
      ac_fg <= sh_fg;
    end
  end

`ifdef GLYPH_BLINK_EN
  logic [NUM_SLOTS-1:0] sh_blink, ac_blink;
  logic [4:0]           frm_cnt;
  logic                 phase;

  always_ff @(posedge lcd_clk) begin
    if (!rstn) begin
      sh_blink <= '0;
      ac_blink <= '0;
    end else begin
      if (cfg_we && (int'(cfg_slot) < NUM_SLOTS))
        sh_blink[cfg_slot] <= cfg_blink;
      if (v_fall)
        ac_blink <= sh_blink;
    end
  end

  always_ff @(posedge lcd_clk) begin
    if (!rstn) begin
      frm_cnt <= '0;
      phase   <= 1'b0;
    end else if (v_fall) begin
      frm_cnt <= frm_cnt + 5'd1;
      if (frm_cnt == 5'd31)
        phase <= ~phase;
    end
  end

  assign vis = ac_en & ~(ac_blink & {NUM_SLOTS{phase}});
`else
  logic unused_blink;
  assign unused_blink = cfg_blink;
  assign vis = ac_en;
`endif

  // Extra top bit keeps slots near the edge from wrapping.
  logic [XW:0] px;
  logic [YW:0] py;
  logic [XW:0] dx [NUM_SLOTS];
  logic [YW:0] dy [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit_v;

  assign px = {1'b0, pix_x};
  assign py = {1'b0, pix_y};

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    logic [XW:0] x0;
    logic [YW:0] y0;
    assign x0       = {1'b0, ac_x[s]};
    assign y0       = {1'b0, ac_y[s]};
    assign dx[s]    = px - x0;
    assign dy[s]    = py - y0;
    assign hit_v[s] = vis[s] & de_in
                    & (px >= x0) & (dx[s] < (XW+1)'(GLYPH_W))
                    & (py >= y0) & (dy[s] < (YW+1)'(GLYPH_H));
  end

  logic              hit_c;
  logic [CW-1:0]     col_c;
  logic [RW-1:0]     row_c;
  logic [GW-1:0]     gly_c;
  logic [23:0]       fg_c;
  logic [ROM_AW-1:0] addr_c;

  always_comb begin
    hit_c = 1'b0;
    col_c = '0;
    row_c = '0;
    gly_c = '0;
    fg_c  = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (hit_v[s]) begin
        hit_c = 1'b1;
        col_c = dx[s][CW-1:0];
        row_c = dy[s][RW-1:0];
        gly_c = ac_g[s];
        fg_c  = ac_fg[s];
      end
    end
  end

  assign addr_c = ROM_AW'(gly_c) * ROM_AW'(GLYPH_H * BPR)
                + ROM_AW'(row_c) * ROM_AW'(BPR)
                + ROM_AW'(col_c >> 3);

  // Index 0 is stage 1; index ROM_LAT lines up with rom_data.
  logic        p_hit [ROM_LAT+1];
  logic [2:0]  p_bit [ROM_LAT+1];
  logic [23:0] p_fg  [ROM_LAT+1];
  logic [23:0] p_bg  [ROM_LAT+1];
  logic        p_de  [ROM_LAT+1];
  logic        p_hs  [ROM_LAT+1];
  logic        p_vs  [ROM_LAT+1];

  always_ff @(posedge lcd_clk) begin
    if (!rstn) begin
      rom_addr <= '0;
      p_hit    <= '{default: 1'b0};
      p_bit    <= '{default: '0};
      p_fg     <= '{default: '0};
      p_bg     <= '{default: '0};
      p_de     <= '{default: 1'b0};
      p_hs     <= '{default: 1'b1};
      p_vs     <= '{default: 1'b1};
    end else begin
      if (hit_c)
        rom_addr <= addr_c;
      p_hit[0] <= hit_c;
      p_bit[0] <= ~col_c[2:0];
      p_fg[0]  <= fg_c;
      p_bg[0]  <= bg_rgb;
      p_de[0]  <= de_in;
      p_hs[0]  <= hsync_in;
      p_vs[0]  <= vsync_in;
      for (int i = 1; i <= ROM_LAT; i++) begin
        p_hit[i] <= p_hit[i-1];
        p_bit[i] <= p_bit[i-1];
        p_fg[i]  <= p_fg[i-1];
        p_bg[i]  <= p_bg[i-1];
        p_de[i]  <= p_de[i-1];
        p_hs[i]  <= p_hs[i-1];
        p_vs[i]  <= p_vs[i-1];
      end
    end
  end

  logic [23:0] pix_c;

  always_comb begin
    pix_c = '0;
    if (p_hit[ROM_LAT] && rom_data[p_bit[ROM_LAT]])
      pix_c = p_fg[ROM_LAT];
    else if (p_de[ROM_LAT])
      pix_c = p_bg[ROM_LAT];
  end

  always_ff @(posedge lcd_clk) begin
    if (!rstn) begin
      {lcd_r, lcd_g, lcd_b} <= '0;
      lcd_de    <= 1'b0;
      lcd_hsync <= 1'b1;
      lcd_vsync <= 1'b1;
    end else begin
      {lcd_r, lcd_g, lcd_b} <= pix_c;
      lcd_de    <= p_de[ROM_LAT];
      lcd_hsync <= p_hs[ROM_LAT];
      lcd_vsync <= p_vs[ROM_LAT];
    end
  end

endmodule

// File: tb/tb_lcd_glyph_overlay.sv
// Directed bench for lcd_glyph_overlay with a 2-cycle model glyph ROM.
// Build with GLYPH_BLINK_EN defined to check the blink schedule.
`timescale 1ns/1ps
module tb_lcd_glyph_overlay;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int AW = 11;
  localparam logic [23:0] BG = 24'h000303;
`ifdef GLYPH_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic          lcd_clk = 1'b0;
  logic          rstn = 1'b0;
  logic [XW-1:0] pix_x = '0;
  logic [YW-1:0] pix_y = '0;
  logic          de_in = 1'b0;
  logic          hsync_in = 1'b1;
  logic          vsync_in = 1'b1;
  logic [23:0]   bg_rgb = BG;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_slot = '0;
  logic          cfg_en = 1'b0;
  logic [XW-1:0] cfg_x = '0;
  logic [YW-1:0] cfg_y = '0;
  logic [3:0]    cfg_glyph = '0;
  logic [23:0]   cfg_fg = '0;
  logic          cfg_blink = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data = '0;
  logic [7:0]    rom_d1 = '0;
  logic [7:0]    lcd_r, lcd_g, lcd_b;
  logic          lcd_de, lcd_hsync, lcd_vsync;

  int errors = 0;
  int checks = 0;

  logic [23:0]   obs_rgb  [64];
  logic          obs_de   [64];
  logic [AW-1:0] obs_addr [64];

  lcd_glyph_overlay dut (
    .lcd_clk(lcd_clk), .rstn(rstn),
    .pix_x(pix_x), .pix_y(pix_y), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_rgb(bg_rgb),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_en(cfg_en),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_glyph(cfg_glyph),
    .cfg_fg(cfg_fg), .cfg_blink(cfg_blink),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync)
  );

  always #5 lcd_clk = ~lcd_clk;

  // Glyph 0: byte 0 = 0x80, rest 0xFF. Glyph 1: solid. Glyph 2+: 0xAA.
  function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
    if (a == '0) return 8'h80;
    if (a < 11'd512) return 8'hFF;
    return 8'hAA;
  endfunction

  always @(posedge lcd_clk) begin
    rom_d1   <= rom_byte(rom_addr);
    rom_data <= rom_d1;
  end

  task automatic tick();
    @(posedge lcd_clk);
    #1;
  endtask

  task automatic idle();
    de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    pix_x = '0; pix_y = '0;
  endtask

  task automatic cfg_write(input int s, input bit en, input int x, input int y,
                           input int g, input logic [23:0] fg, input bit bl);
    cfg_slot = 3'(s); cfg_en = en; cfg_x = XW'(x); cfg_y = YW'(y);
    cfg_glyph = 4'(g); cfg_fg = fg; cfg_blink = bl; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic vsync_pulse();
    idle();
    vsync_in = 1'b0; tick(); tick();
    vsync_in = 1'b1; tick(); tick();
  endtask

  // Drive n active pixels; obs_* index i holds the result for pixel i.
  task automatic run_line(input int y, input int x0, input int n);
    for (int k = 0; k < n + 7; k++) begin
      pix_y = YW'(y);
      pix_x = (k < n) ? XW'(x0 + k) : '0;
      de_in = (k < n);
      hsync_in = 1'b1; vsync_in = 1'b1;
      tick();
      if (k < 64) obs_addr[k] = rom_addr;
      if (k >= 3 && k - 3 < 64) begin
        obs_rgb[k-3] = {lcd_r, lcd_g, lcd_b};
        obs_de[k-3]  = lcd_de;
      end
    end
    idle();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    de_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    pix_x = 11'd300; pix_y = 10'd100;
    repeat (3) tick();
    checks++; if (lcd_de !== 1'b0) begin errors++; $display("FAIL rst_de got %b want 0", lcd_de); end
    checks++; if (lcd_hsync !== 1'b1) begin errors++; $display("FAIL rst_hs got %b want 1", lcd_hsync); end
    checks++; if (lcd_vsync !== 1'b1) begin errors++; $display("FAIL rst_vs got %b want 1", lcd_vsync); end
    checks++; if ({lcd_r, lcd_g, lcd_b} !== 24'h0) begin errors++; $display("FAIL rst_rgb got %h want 000000", {lcd_r, lcd_g, lcd_b}); end
    checks++; if (rom_addr !== '0) begin errors++; $display("FAIL rst_addr got %0d want 0", rom_addr); end
    idle();
    rstn = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_background();
    run_line(10, 0, 16);
    for (int i = 0; i < 20; i++) begin
      logic [23:0] e;
      e = (i < 16) ? BG : 24'h0;
      checks++; if (obs_rgb[i] !== e) begin errors++; $display("FAIL bg_rgb[%0d] got %h want %h", i, obs_rgb[i], e); end
      checks++; if (obs_de[i] !== (i < 16)) begin errors++; $display("FAIL bg_de[%0d] got %b want %b", i, obs_de[i], (i < 16)); end
    end
  endtask

  task automatic test_controls();
    for (int k = 0; k < 19; k++) begin
      if (k < 16) begin
        hsync_in = (k % 3) != 0;
        vsync_in = (k % 5) != 0;
        de_in = k[0];
        pix_x = XW'(k); pix_y = 10'd5;
      end else idle();
      tick();
      if (k >= 3) begin
        int j;
        bit ehs, evs, ede;
        j = k - 3;
        ehs = (j % 3) != 0; evs = (j % 5) != 0; ede = j[0];
        checks++; if (lcd_hsync !== ehs) begin errors++; $display("FAIL ctl_hs[%0d] got %b want %b", j, lcd_hsync, ehs); end
        checks++; if (lcd_vsync !== evs) begin errors++; $display("FAIL ctl_vs[%0d] got %b want %b", j, lcd_vsync, evs); end
        checks++; if (lcd_de !== ede) begin errors++; $display("FAIL ctl_de[%0d] got %b want %b", j, lcd_de, ede); end
        checks++; if ({lcd_r, lcd_g, lcd_b} !== (ede ? BG : 24'h0)) begin errors++; $display("FAIL ctl_rgb[%0d] got %h want %h", j, {lcd_r, lcd_g, lcd_b}, (ede ? BG : 24'h0)); end
      end
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_single_glyph();
    cfg_write(0, 1, 300, 100, 0, 24'hFF0000, 0);
    vsync_pulse();
    run_line(100, 296, 16);
    for (int i = 0; i < 16; i++) begin
      int x;
      logic [23:0] e;
      x = 296 + i;
      e = (x == 300 || x >= 308) ? 24'hFF0000 : BG;
      checks++; if (obs_rgb[i] !== e) begin errors++; $display("FAIL g0_x%0d got %h want %h", x, obs_rgb[i], e); end
    end
    checks++; if (obs_addr[4] !== 11'd0) begin errors++; $display("FAIL g0_addr300 got %0d want 0", obs_addr[4]); end
    checks++; if (obs_addr[13] !== 11'd1) begin errors++; $display("FAIL g0_addr309 got %0d want 1", obs_addr[13]); end
    run_line(163, 300, 1);
    checks++; if (obs_rgb[0] !== 24'hFF0000) begin errors++; $display("FAIL g0_lastrow got %h want ff0000", obs_rgb[0]); end
    checks++; if (obs_addr[0] !== 11'd252) begin errors++; $display("FAIL g0_addr_row63 got %0d want 252", obs_addr[0]); end
    run_line(164, 300, 1);
    checks++; if (obs_rgb[0] !== BG) begin errors++; $display("FAIL g0_below got %h want %h", obs_rgb[0], BG); end
    checks++; if (obs_addr[0] !== 11'd252) begin errors++; $display("FAIL addr_hold got %0d want 252", obs_addr[0]); end
  endtask

  task automatic test_address();
    cfg_write(3, 1, 10, 20, 2, 24'h00FF00, 0);
    vsync_pulse();
    run_line(21, 8, 12);
    checks++; if (obs_addr[10] !== 11'd517) begin errors++; $display("FAIL addr_18_21 got %0d want 517", obs_addr[10]); end
    checks++; if (obs_addr[2] !== 11'd516) begin errors++; $display("FAIL addr_10_21 got %0d want 516", obs_addr[2]); end
    for (int i = 0; i < 12; i++) begin
      int x;
      logic [23:0] e;
      x = 8 + i;
      e = (x >= 10 && ((x - 10) % 2) == 0) ? 24'h00FF00 : BG;
      checks++; if (obs_rgb[i] !== e) begin errors++; $display("FAIL g2_x%0d got %h want %h", x, obs_rgb[i], e); end
    end
  endtask

  task automatic test_priority();
    cfg_write(1, 1, 200, 50, 1, 24'h0000FF, 0);
    cfg_write(5, 1, 216, 50, 1, 24'hFFFF00, 0);
    vsync_pulse();
    run_line(50, 196, 56);
    for (int i = 0; i < 56; i++) begin
      int x;
      logic [23:0] e;
      x = 196 + i;
      if (x < 200) e = BG;
      else if (x < 232) e = 24'h0000FF;
      else if (x < 248) e = 24'hFFFF00;
      else e = BG;
      checks++; if (obs_rgb[i] !== e) begin errors++; $display("FAIL prio_x%0d got %h want %h", x, obs_rgb[i], e); end
    end
  endtask

  task automatic check_row(input string nm, input int x0, input int n,
                           input int lo, input int hi, input logic [23:0] fg);
    for (int i = 0; i < n; i++) begin
      logic [23:0] e;
      e = (x0 + i >= lo && x0 + i < hi) ? fg : BG;
      checks++; if (obs_rgb[i] !== e) begin errors++; $display("FAIL %s_x%0d got %h want %h", nm, x0 + i, obs_rgb[i], e); end
    end
  endtask

  task automatic test_shadow();
    run_line(150, 296, 8);
    check_row("sh_pre", 296, 8, 300, 332, 24'hFF0000);
    cfg_write(0, 1, 100, 100, 0, 24'hFF0000, 0);
    run_line(150, 96, 8);
    check_row("sh_cur_new", 96, 8, 0, 0, 24'hFF0000);
    run_line(150, 296, 8);
    check_row("sh_cur_old", 296, 8, 300, 332, 24'hFF0000);
    vsync_pulse();
    run_line(150, 96, 8);
    check_row("sh_next_new", 96, 8, 100, 132, 24'hFF0000);
    run_line(150, 296, 8);
    check_row("sh_next_old", 296, 8, 0, 0, 24'hFF0000);
    // write coincident with the vsync falling edge
    idle();
    cfg_slot = 3'd6; cfg_en = 1'b1; cfg_x = '0; cfg_y = 10'd200;
    cfg_glyph = 4'd1; cfg_fg = 24'hFFFFFF; cfg_blink = 1'b0;
    cfg_we = 1'b1; vsync_in = 1'b0;
    tick();
    cfg_we = 1'b0;
    tick();
    vsync_in = 1'b1; tick(); tick();
    run_line(200, 0, 4);
    check_row("same_cyc_cur", 0, 4, 0, 0, 24'hFFFFFF);
    vsync_pulse();
    run_line(200, 0, 4);
    check_row("same_cyc_next", 0, 4, 0, 32, 24'hFFFFFF);
  endtask

  task automatic test_clip();
    cfg_write(2, 1, 470, 0, 1, 24'h00FFFF, 0);
    vsync_pulse();
    run_line(0, 466, 14);
    check_row("clip_r", 466, 14, 470, 480, 24'h00FFFF);
    run_line(0, 0, 4);
    check_row("clip_wrap", 0, 4, 0, 0, 24'h00FFFF);
  endtask

  task automatic test_reset_midframe();
    pix_y = 10'd150; de_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pix_x = XW'(100 + k);
      tick();
    end
    rstn = 1'b0;
    tick();
    checks++; if (lcd_de !== 1'b0) begin errors++; $display("FAIL mid_rst_de got %b want 0", lcd_de); end
    checks++; if (lcd_hsync !== 1'b1) begin errors++; $display("FAIL mid_rst_hs got %b want 1", lcd_hsync); end
    checks++; if ({lcd_r, lcd_g, lcd_b} !== 24'h0) begin errors++; $display("FAIL mid_rst_rgb got %h want 000000", {lcd_r, lcd_g, lcd_b}); end
    rstn = 1'b1;
    tick();
    checks++; if (lcd_de !== 1'b0) begin errors++; $display("FAIL post_rst_de got %b want 0", lcd_de); end
    idle();
    repeat (4) tick();
    run_line(150, 100, 4);
    check_row("post_rst_cleared", 100, 4, 0, 0, 24'hFF0000);
  endtask

  task automatic test_blink();
    cfg_write(4, 1, 0, 0, 1, 24'hFF00FF, 1);
    for (int f = 1; f <= 64; f++) begin
      vsync_pulse();
      if (f == 1 || f == 31 || f == 32 || f == 63 || f == 64) begin
        logic [23:0] e;
        run_line(0, 0, 1);
        e = (!BLINK || (f % 64) < 32) ? 24'hFF00FF : BG;
        checks++; if (obs_rgb[0] !== e) begin errors++; $display("FAIL blink_f%0d got %h want %h", f, obs_rgb[0], e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_background();
    test_controls();
    test_single_glyph();
    test_address();
    test_priority();
    test_shadow();
    test_clip();
    test_reset_midframe();
    test_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
